// File: rtl/debounce_multi.sv
// Multi-channel key debouncer: 2-FF synchroniser and consecutive-sample filter per channel,
// press/release/long-press pulses, optional auto-repeat, and a lowest-index-first event port.
// Optional feature: define DEBOUNCE_REPEAT_EN to build the auto-repeat timers.
module debounce_multi #(
  parameter int unsigned CH        = 4,
  parameter int unsigned N         = 5,
  parameter int unsigned LONG_MS   = 500,
  parameter int unsigned REPEAT_MS = 100
) (
  input  logic                                  clk_1000hz,
  input  logic                                  rst_n,
  input  logic [CH-1:0]                         key,
  output logic [CH-1:0]                         is_pressed,
  output logic [CH-1:0]                         press_pulse,
  output logic [CH-1:0]                         release_pulse,
  output logic [CH-1:0]                         long_pulse,
  output logic [CH-1:0]                         repeat_pulse,
  output logic                                  evt_valid,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] evt_ch
);

  localparam int unsigned CntW  = $clog2(N);
  localparam int unsigned HoldW = $clog2(LONG_MS + 1);
  localparam int unsigned ChW   = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0]    sync0_q, sync1_q;
  logic [CH-1:0]    st_q, st_d;
  logic [CntW-1:0]  cnt_q [CH];
  logic [CntW-1:0]  cnt_d [CH];
  logic [HoldW-1:0] hold_q [CH];
  logic [HoldW-1:0] hold_d [CH];
  logic [CH-1:0]    press_q, press_d, rel_q, rel_d, long_q, long_d;
  logic [CH-1:0]    rep_pulse_q, rep_pulse_d;
  logic [CH-1:0]    pend_q, pend_d;
  logic             evt_valid_q, evt_valid_d;
  logic [ChW-1:0]   evt_ch_q, evt_ch_d;

  // Filter: st follows the synchronised sample only after N consecutive disagreeing samples.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = '0;
      // Sample is active-high pressed (~sync1), so it disagrees with st when sync1 == st.
      if (sync1_q[i] == st_q[i]) begin
        if (cnt_q[i] == CntW'(N - 1)) begin
          st_d[i] = ~sync1_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Edge pulses and saturating hold timer; long pulse when hold first reaches LONG_MS.
  always_comb begin
    press_d = st_d & ~st_q;
    rel_d   = ~st_d & st_q;
    for (int i = 0; i < CH; i++) begin
      hold_d[i] = '0;
      long_d[i] = 1'b0;
      if (st_q[i] && st_d[i]) begin
        if (hold_q[i] == HoldW'(LONG_MS)) begin
          hold_d[i] = hold_q[i];
        end else begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
        long_d[i] = (hold_q[i] == HoldW'(LONG_MS - 1));
      end
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_MS);

  logic [RepW-1:0] rep_q [CH];
  logic [RepW-1:0] rep_d [CH];

  // Repeat timer runs only once the hold timer has saturated and the key is still held.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      rep_d[i]       = '0;
      rep_pulse_d[i] = 1'b0;
      if (st_q[i] && st_d[i] && (hold_q[i] == HoldW'(LONG_MS))) begin
        if (rep_q[i] == RepW'(REPEAT_MS - 1)) begin
          rep_pulse_d[i] = 1'b1;
        end else begin
          rep_d[i] = rep_q[i] + 1'b1;
        end
      end
    end
  end

  // Repeat timer state.
  always_ff @(posedge clk_1000hz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) rep_q[i] <= '0;
    end else begin
      for (int i = 0; i < CH; i++) rep_q[i] <= rep_d[i];
    end
  end
`else
  assign rep_pulse_d = '0;
`endif

  // Event encoder: present the lowest pending index, clear it; new sets win over the clear.
  always_comb begin
    pend_d      = pend_q;
    evt_valid_d = 1'b0;
    evt_ch_d    = '0;
    for (int i = int'(CH) - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        evt_valid_d = 1'b1;
        evt_ch_d    = ChW'(i);
      end
    end
    if (evt_valid_d) pend_d[evt_ch_d] = 1'b0;
    pend_d = pend_d | press_d | rep_pulse_d;
  end

  // All channel and event state, asynchronously cleared.
  always_ff @(posedge clk_1000hz or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q     <= '1;
      sync1_q     <= '1;
      st_q        <= '0;
      press_q     <= '0;
      rel_q       <= '0;
      long_q      <= '0;
      rep_pulse_q <= '0;
      pend_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]  <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      sync0_q     <= key;
      sync1_q     <= sync0_q;
      st_q        <= st_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      long_q      <= long_d;
      rep_pulse_q <= rep_pulse_d;
      pend_q      <= pend_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign is_pressed    = st_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = rep_pulse_q;
  assign evt_valid     = evt_valid_q;
  assign evt_ch        = evt_ch_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus random bouncing, every cycle compared
// against a time-based reference model (sample windows, press timestamps, pending set).
module tb_debounce_multi;

  localparam int unsigned CH   = 4;
  localparam int unsigned N    = 5;
  localparam int unsigned LONG = 500;
  localparam int unsigned REP  = 100;
  localparam int unsigned ChW  = 2;

  logic           clk, rst_n;
  logic [CH-1:0]  key;
  logic [CH-1:0]  is_pressed, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic           evt_valid;
  logic [ChW-1:0] evt_ch;

  int errors = 0;
  int checks = 0;

  debounce_multi #(.CH(CH), .N(N), .LONG_MS(LONG), .REPEAT_MS(REP)) dut (
    .clk_1000hz   (clk),
    .rst_n        (rst_n),
    .key          (key),
    .is_pressed   (is_pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .evt_valid    (evt_valid),
    .evt_ch       (evt_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit [CH-1:0]  kd1, kd2;          // key seen at previous edge and the edge before
  bit [N-1:0]   win [CH];          // last N synchronised samples, 1 = pressed
  bit [CH-1:0]  m_st, m_pend;
  longint       press_cyc [CH];
  longint       cyc;
  bit [CH-1:0]  e_press, e_rel, e_long, e_rep;
  bit           e_valid;
  bit [ChW-1:0] e_ch;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    kd1 = '1; kd2 = '1; m_st = '0; m_pend = '0; cyc = 0;
    e_press = '0; e_rel = '0; e_long = '0; e_rep = '0; e_valid = 1'b0; e_ch = '0;
    for (int i = 0; i < CH; i++) begin
      win[i] = '0;
      press_cyc[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit [CH-1:0] s, old_st, old_pend;
    longint d;
    if (!rst_n) return;
    cyc++;
    s = ~kd2;
    old_st = m_st;
    for (int i = 0; i < CH; i++) begin
      win[i] = {win[i][N-2:0], s[i]};
      // Flip once the whole window disagrees with the stable state.
      if (win[i] == (old_st[i] ? {N{1'b0}} : {N{1'b1}})) m_st[i] = ~old_st[i];
      e_press[i] = m_st[i] & ~old_st[i];
      e_rel[i]   = ~m_st[i] & old_st[i];
      if (e_press[i]) press_cyc[i] = cyc;
      d = cyc - press_cyc[i];
      e_long[i] = old_st[i] && m_st[i] && (d == LONG);
`ifdef DEBOUNCE_REPEAT_EN
      e_rep[i]  = old_st[i] && m_st[i] && (d > LONG) && (((d - LONG) % REP) == 0);
`else
      e_rep[i]  = 1'b0;
`endif
    end
    old_pend = m_pend;
    e_valid = 1'b0;
    e_ch = '0;
    for (int i = 0; i < CH; i++) begin
      if (old_pend[i] && !e_valid) begin
        e_valid = 1'b1;
        e_ch = ChW'(i);
      end
    end
    if (e_valid) old_pend[e_ch] = 1'b0;
    m_pend = old_pend | e_press | e_rep;
    kd2 = kd1;
    kd1 = key;
  endtask

  task automatic compare_all();
    check_eq("is_pressed", 32'(is_pressed), 32'(m_st));
    check_eq("press_pulse", 32'(press_pulse), 32'(e_press));
    check_eq("release_pulse", 32'(release_pulse), 32'(e_rel));
    check_eq("long_pulse", 32'(long_pulse), 32'(e_long));
    check_eq("repeat_pulse", 32'(repeat_pulse), 32'(e_rep));
    check_eq("evt_valid", 32'(evt_valid), 32'(e_valid));
    if (e_valid) check_eq("evt_ch", 32'(evt_ch), 32'(e_ch));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Each cycle every channel flips with probability 1/div.
  task automatic random_phase(input int n, input int unsigned div);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(div - 1, 0) == 0) key[c] = ~key[c];
      end
      step();
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq(tag, 32'({is_pressed, press_pulse, release_pulse, long_pulse, repeat_pulse,
                       evt_valid, evt_ch}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    key   = '1;
    model_reset();
    #1;
    check_zero("reset_outputs");
    run(3);
    rst_n = 1'b1;
    run(10);

    // Clean press on channel 2.
    key[2] = 1'b0;
    run(20);
    key[2] = 1'b1;
    run(12);

    // Glitch of N-1 samples: no change expected.
    key[0] = 1'b0;
    run(N - 1);
    key[0] = 1'b1;
    run(10);

    // Bounce on channel 0, then settle pressed.
    for (int i = 0; i < 10; i++) begin
      key[0] = ~key[0];
      run(2);
    end
    key[0] = 1'b0;
    run(15);
    key[0] = 1'b1;
    run(12);

    // Simultaneous press of channels 3 and 1.
    key[3] = 1'b0;
    key[1] = 1'b0;
    run(20);
    key = '1;
    run(12);

    // Long hold on channel 0: long pulse and (if built) repeats.
    key[0] = 1'b0;
    run(810);
    key[0] = 1'b1;
    run(15);

    // Release partway between long and first repeat.
    key[1] = 1'b0;
    run(N + 2 + 550);
    key[1] = 1'b1;
    run(700);

    // Random bouncing at several intensities.
    random_phase(1500, 3);
    random_phase(1500, 20);
    random_phase(3000, 400);
    key = '1;
    run(20);

    // Reset mid-hold with a filter count in flight on channel 0.
    key[2] = 1'b0;
    run(600);
    key[0] = 1'b0;
    run(4);
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    model_reset();
    run(3);
    @(negedge clk);
    rst_n = 1'b1;
    run(30);
    key = '1;
    run(15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
